avmm_host_adapter: RTL and testbench

- Upstream request stage that feeds the AVMM memory model.
- Accepts tagged read/write commands from a host over a valid/ready channel and holds each one in a single-entry command register until the memory asserts ready.
- Keeps a credit count of outstanding reads, matches in-order readdata to the issuing tag, and returns the responses through a back-pressurable response FIFO.
- Flags protocol errors and read timeouts.

---
 rtl/avmm_host_adapter_if.sv | 58 +++++
 rtl/avmm_host_adapter.sv | 152 +++++++++++++++
 tb/tb_avmm_host_adapter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_host_adapter_if.sv
// Bundles the host request/response channels, the memory-side command/read-data
// channel and the status outputs of avmm_host_adapter. The adapter uses the slave
// modport; a host/environment driving the adapter uses the master modport.
interface avmm_host_adapter_if #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned TAG_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 16
);
  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING) + 1;

  // Host command channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [51:6]           req_address;
  logic [BeWidth-1:0]    req_byteenable;
  logic [DATA_WIDTH-1:0] req_writedata;
  logic [TAG_WIDTH-1:0]  req_tag;
  // Memory command and read-data channel
  logic                  avm_read;
  logic                  avm_write;
  logic [51:6]           avm_address;
  logic [BeWidth-1:0]    avm_byteenable;
  logic [DATA_WIDTH-1:0] avm_writedata;
  logic                  avm_ready;
  logic [DATA_WIDTH-1:0] avm_readdata;
  logic                  avm_readdatavalid;
  // Host response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  // Status
  logic [CntWidth-1:0]   outstanding;
  logic                  err_unexpected;
  logic                  err_timeout;

  modport slave (
    input  req_valid, req_write, req_address, req_byteenable, req_writedata, req_tag,
    output req_ready,
    output avm_read, avm_write, avm_address, avm_byteenable, avm_writedata,
    input  avm_ready, avm_readdata, avm_readdatavalid,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready,
    output outstanding, err_unexpected, err_timeout
  );

  modport master (
    output req_valid, req_write, req_address, req_byteenable, req_writedata, req_tag,
    input  req_ready,
    input  avm_read, avm_write, avm_address, avm_byteenable, avm_writedata,
    output avm_ready, avm_readdata, avm_readdatavalid,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready,
    input  outstanding, err_unexpected, err_timeout
  );
endinterface

// File: rtl/avmm_host_adapter.sv
// Host-side request stage for the AVMM memory: single-entry command register,
// read-credit accounting, in-order tag matching and a response FIFO, plus sticky
// unexpected-readdata and read-timeout flags.
module avmm_host_adapter #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned TAG_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned DATA_WIDTH      = 512
) (
  input logic                clk,
  input logic                rst,
  avmm_host_adapter_if.slave bus
);
  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned PtrWidth = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam int unsigned ToWidth  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntWidth-1:0] MaxCredits = CntWidth'(MAX_OUTSTANDING);
  localparam logic [ToWidth-1:0]  ToLast     = ToWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StEmpty, StHold} state_e;

  state_e                r_state, w_state_d;
  logic                  r_hold_write;
  logic [51:6]           r_hold_addr;
  logic [BeWidth-1:0]    r_hold_be;
  logic [DATA_WIDTH-1:0] r_hold_wdata;
  logic [TAG_WIDTH-1:0]  r_hold_tag;
  logic [CntWidth-1:0]   r_credits;
  logic [TAG_WIDTH-1:0]  r_tag_mem [MAX_OUTSTANDING];
  logic [CntWidth-1:0]   r_tag_wptr, r_tag_rptr;
  logic [DATA_WIDTH-1:0] r_rsp_data_mem [MAX_OUTSTANDING];
  logic [TAG_WIDTH-1:0]  r_rsp_tag_mem [MAX_OUTSTANDING];
  logic [CntWidth-1:0]   r_rsp_wptr, r_rsp_rptr;
  logic [ToWidth-1:0]    r_to_cnt;
  logic                  r_err_unexpected, r_err_timeout;

  logic w_req_ready, w_accept, w_issue, w_issue_read;
  logic w_tag_empty, w_tag_pop, w_rsp_empty, w_rsp_push, w_rsp_pop;

  // A read needs a free credit so its response slot is reserved before issue.
  assign w_req_ready  = (r_state == StEmpty) & ~rst & (bus.req_write | (r_credits != '0));
  assign w_accept     = bus.req_valid & w_req_ready;
  assign w_issue      = (r_state == StHold) & bus.avm_ready;
  assign w_issue_read = w_issue & ~r_hold_write;
  assign w_tag_empty  = (r_tag_wptr == r_tag_rptr);
  assign w_tag_pop    = bus.avm_readdatavalid & ~w_tag_empty;
  assign w_rsp_empty  = (r_rsp_wptr == r_rsp_rptr);
  assign w_rsp_push   = w_tag_pop;
  assign w_rsp_pop    = ~w_rsp_empty & bus.rsp_ready;

  // Command register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StEmpty;
    else     r_state <= w_state_d;
  end

  // Command register next state: capture on accept, release on issue
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StEmpty: if (w_accept) w_state_d = StHold;
      StHold:  if (w_issue)  w_state_d = StEmpty;
      default: w_state_d = StEmpty;
    endcase
  end

  // Held command fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_write <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_be    <= '0;
      r_hold_wdata <= '0;
      r_hold_tag   <= '0;
    end else if (w_accept) begin
      r_hold_write <= bus.req_write;
      r_hold_addr  <= bus.req_address;
      r_hold_be    <= bus.req_byteenable;
      r_hold_wdata <= bus.req_writedata;
      r_hold_tag   <= bus.req_tag;
    end
  end

  // Read credits: spent on read issue, returned when the host pops the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= MaxCredits;
    end else begin
      case ({w_issue_read, w_rsp_pop})
        2'b10:   r_credits <= r_credits - CntWidth'(1);
        2'b01:   r_credits <= r_credits + CntWidth'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Pointers of the tag and response FIFOs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
      r_rsp_wptr <= '0;
      r_rsp_rptr <= '0;
    end else begin
      if (w_issue_read) r_tag_wptr <= r_tag_wptr + CntWidth'(1);
      if (w_tag_pop)    r_tag_rptr <= r_tag_rptr + CntWidth'(1);
      if (w_rsp_push)   r_rsp_wptr <= r_rsp_wptr + CntWidth'(1);
      if (w_rsp_pop)    r_rsp_rptr <= r_rsp_rptr + CntWidth'(1);
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark them empty
  always_ff @(posedge clk) begin
    if (w_issue_read) r_tag_mem[r_tag_wptr[PtrWidth-1:0]] <= r_hold_tag;
    if (w_rsp_push) begin
      r_rsp_data_mem[r_rsp_wptr[PtrWidth-1:0]] <= bus.avm_readdata;
      r_rsp_tag_mem[r_rsp_wptr[PtrWidth-1:0]]  <= r_tag_mem[r_tag_rptr[PtrWidth-1:0]];
    end
  end

  // Read timeout watchdog and unexpected-readdata flag, both sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt         <= '0;
      r_err_timeout    <= 1'b0;
      r_err_unexpected <= 1'b0;
    end else begin
      if (bus.avm_readdatavalid && w_tag_empty) r_err_unexpected <= 1'b1;
      if (bus.avm_readdatavalid || w_tag_empty) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == ToLast) begin
        r_err_timeout <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + ToWidth'(1);
      end
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.avm_write      = (r_state == StHold) & r_hold_write;
  assign bus.avm_read       = (r_state == StHold) & ~r_hold_write;
  assign bus.avm_address    = r_hold_addr;
  assign bus.avm_byteenable = r_hold_write ? r_hold_be : {BeWidth{1'b1}};
  assign bus.avm_writedata  = r_hold_wdata;
  assign bus.rsp_valid      = ~w_rsp_empty;
  assign bus.rsp_data       = w_rsp_empty ? '0 : r_rsp_data_mem[r_rsp_rptr[PtrWidth-1:0]];
  assign bus.rsp_tag        = w_rsp_empty ? '0 : r_rsp_tag_mem[r_rsp_rptr[PtrWidth-1:0]];
  assign bus.outstanding    = MaxCredits - r_credits;
  assign bus.err_unexpected = r_err_unexpected;
  assign bus.err_timeout    = r_err_timeout;
endmodule

// File: tb/tb_avmm_host_adapter.sv
// Self-checking bench for avmm_host_adapter: a latency-programmable memory
// responder plus a command-order reference memory predicting every response.
module tb_avmm_host_adapter;
  localparam int unsigned Max      = 16;
  localparam int unsigned TagW     = 8;
  localparam int unsigned ToCycles = 64;
  localparam int unsigned DW       = 64;
  localparam int unsigned BW       = DW / 8;

  typedef struct {logic [DW-1:0] data; logic [TagW-1:0] tag;} rsp_t;
  typedef struct {int due; logic [DW-1:0] data;} pend_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avmm_host_adapter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TagW), .MAX_OUTSTANDING(Max)) bus ();

  avmm_host_adapter #(
    .MAX_OUTSTANDING(Max),
    .TAG_WIDTH      (TagW),
    .TIMEOUT_CYCLES (ToCycles),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] ref_mem [logic [45:0]];   // reference: memory image in host command order
  logic [DW-1:0] mem_mem [logic [45:0]];   // responder: memory image in issue order
  rsp_t  exp_q[$];
  pend_t pend_q[$];
  logic [TagW-1:0] pop_tags[$];

  int lat = 4;
  int rdy_mode = 1;   // 0 never, 1 always, 2 alternate, 3 random
  int rsp_mode = 1;   // 0 never, 1 always, 2 toggle, 3 random
  bit force_rdv = 0;
  bit acc = 0;
  int n_wr_issue = 0, n_rd_issue = 0, n_acc_wr = 0, n_acc_rd = 0;
  int last_rd_issue_cyc = 0, last_pop_cyc = 0;
  logic [DW-1:0] last_pop_data;
  logic [TagW-1:0] last_pop_tag;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // One clock cycle: drive environment inputs, settle, observe handshakes, advance.
  task automatic tick();
    bit presented;
    logic [DW-1:0] cur;
    case (rdy_mode)
      0:       bus.avm_ready = 1'b0;
      1:       bus.avm_ready = 1'b1;
      2:       bus.avm_ready = cyc[0];
      default: bus.avm_ready = 1'($urandom_range(0, 1));
    endcase
    case (rsp_mode)
      0:       bus.rsp_ready = 1'b0;
      1:       bus.rsp_ready = 1'b1;
      2:       bus.rsp_ready = cyc[0];
      default: bus.rsp_ready = 1'($urandom_range(0, 1));
    endcase
    presented = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    bus.avm_readdatavalid = presented | force_rdv;
    bus.avm_readdata = presented ? pend_q[0].data : {$urandom, $urandom};
    #1;
    acc = 0;
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) begin
        acc = 1;
        cur = ref_mem.exists(bus.req_address) ? ref_mem[bus.req_address] : '0;
        if (bus.req_write) begin
          ref_mem[bus.req_address] = merge(cur, bus.req_writedata, bus.req_byteenable);
          n_acc_wr++;
        end else begin
          exp_q.push_back('{data: cur, tag: bus.req_tag});
          n_acc_rd++;
        end
      end
      if (presented) void'(pend_q.pop_front());
      if (bus.avm_ready && bus.avm_write) begin
        cur = mem_mem.exists(bus.avm_address) ? mem_mem[bus.avm_address] : '0;
        mem_mem[bus.avm_address] = merge(cur, bus.avm_writedata, bus.avm_byteenable);
        n_wr_issue++;
      end
      if (bus.avm_ready && bus.avm_read) begin
        chk("rd_byteenable", 64'(bus.avm_byteenable), 64'({BW{1'b1}}));
        cur = mem_mem.exists(bus.avm_address) ? mem_mem[bus.avm_address] : '0;
        pend_q.push_back('{due: cyc + lat, data: cur});
        n_rd_issue++;
        last_rd_issue_cyc = cyc;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        last_pop_cyc  = cyc;
        last_pop_data = bus.rsp_data;
        last_pop_tag  = bus.rsp_tag;
        pop_tags.push_back(bus.rsp_tag);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected_pop", 64'(exp_q.size()), 64'd1);
        end else begin
          chk("rsp_data", 64'(bus.rsp_data), 64'(exp_q[0].data));
          chk("rsp_tag", 64'(bus.rsp_tag), 64'(exp_q[0].tag));
          void'(exp_q.pop_front());
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input bit w, input logic [45:0] a, input logic [BW-1:0] be,
                      input logic [DW-1:0] d, input logic [TagW-1:0] t);
    bus.req_valid      = 1'b1;
    bus.req_write      = w;
    bus.req_address    = a;
    bus.req_byteenable = be;
    bus.req_writedata  = d;
    bus.req_tag        = t;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (acc) break;
    end
    bus.req_valid = 1'b0;
    if (!acc) chk("send_accept_timeout", 64'(acc), 64'd1);
  endtask

  // Run until every accepted command is issued and every response consumed.
  task automatic drain();
    bit done;
    done = 0;
    rsp_mode = 1;
    if (rdy_mode == 0) rdy_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && pend_q.size() == 0 && n_rd_issue == n_acc_rd &&
          n_wr_issue == n_acc_wr) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) chk("drain_timeout", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    force_rdv = 0;
    pend_q.delete();
    exp_q.delete();
    n_wr_issue = 0; n_rd_issue = 0; n_acc_wr = 0; n_acc_rd = 0;
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [45:0] addrs [3];
    logic [TagW-1:0] tags [3];
    int n0;
    bit stable;

    bus.req_valid = 0; bus.req_write = 0; bus.req_address = '0; bus.req_byteenable = '0;
    bus.req_writedata = '0; bus.req_tag = '0; bus.avm_ready = 0; bus.avm_readdata = '0;
    bus.avm_readdatavalid = 0; bus.rsp_ready = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_avm_read", 64'(bus.avm_read), 64'd0);
    chk("rst_avm_write", 64'(bus.avm_write), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
    chk("rst_err_unexpected", 64'(bus.err_unexpected), 64'd0);
    chk("rst_err_timeout", 64'(bus.err_timeout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Write then read back through a 100-cycle memory
    rdy_mode = 2; lat = 100; rsp_mode = 1;
    send(1, 46'h10, {BW{1'b1}}, 64'hA5, 8'h0);
    send(0, 46'h10, '0, '0, 8'h3);
    drain();
    chk("t1_write_issues", 64'(n_wr_issue), 64'd1);
    chk("t1_read_issues", 64'(n_rd_issue), 64'd1);
    chk("t1_rsp_data", 64'(last_pop_data), 64'hA5);
    chk("t1_rsp_tag", 64'(last_pop_tag), 64'h3);
    chk("t1_latency_ok", 64'((last_pop_cyc - last_rd_issue_cyc >= 100) &&
                             (last_pop_cyc - last_rd_issue_cyc <= 102)), 64'd1);
    do_reset();

    // Credit exhaustion: 16 reads with the host not draining responses
    rdy_mode = 2; lat = 10; rsp_mode = 0;
    for (int i = 0; i < 16; i++) send(0, 46'(i % 4 + 'h10), '0, '0, 8'(i));
    rsp_mode = 0;
    ticks(40);
    chk("t2_read_issues", 64'(n_rd_issue), 64'd16);
    chk("t2_outstanding_full", 64'(bus.outstanding), 64'd16);
    bus.req_valid = 1; bus.req_write = 0; bus.req_address = 46'h11; bus.req_tag = 8'd16;
    #1;
    chk("t2_read_blocked_ready", 64'(bus.req_ready), 64'd0);
    tick();
    chk("t2_read_blocked_acc", 64'(acc), 64'd0);
    send(1, 46'h12, 8'h0F, 64'h1122334455667788, 8'h0);
    ticks(4);
    chk("t2_write_issued", 64'(n_wr_issue), 64'd1);
    bus.req_valid = 1; bus.req_write = 0; bus.req_address = 46'h12; bus.req_tag = 8'd16;
    tick();
    chk("t2_still_blocked", 64'(acc), 64'd0);
    rsp_mode = 1;
    tick();
    chk("t2_pop_cycle_blocked", 64'(acc), 64'd0);
    rsp_mode = 0;
    tick();
    chk("t2_read_after_pop", 64'(acc), 64'd1);
    bus.req_valid = 0;
    drain();

    // Memory stalls with a read held in the command register
    rdy_mode = 0; lat = 5;
    n0 = n_rd_issue;
    send(0, 46'h2A, '0, '0, 8'h7);
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      if (!(bus.avm_read === 1'b1 && bus.avm_address === 46'h2A && bus.req_ready === 1'b0))
        stable = 0;
      tick();
    end
    chk("t3_hold_stable", 64'(stable), 64'd1);
    chk("t3_no_issue", 64'(n_rd_issue - n0), 64'd0);
    chk("t3_no_credit_used", 64'(bus.outstanding), 64'd0);
    rdy_mode = 1;
    ticks(3);
    chk("t3_issued_once", 64'(n_rd_issue - n0), 64'd1);
    drain();

    // In-order tag return with the host toggling rsp_ready
    rdy_mode = 2; lat = 3;
    addrs[0] = 46'h40; addrs[1] = 46'h41; addrs[2] = 46'h42;
    tags[0] = 8'd5; tags[1] = 8'd9; tags[2] = 8'd2;
    for (int i = 0; i < 3; i++)
      send(1, addrs[i], 8'($urandom_range(1, 255)), {$urandom, $urandom}, 8'h0);
    drain();
    pop_tags.delete();
    rsp_mode = 2;
    for (int i = 0; i < 3; i++) send(0, addrs[i], '0, '0, tags[i]);
    send(0, addrs[0], '0, '0, 8'd11);
    rsp_mode = 2;
    ticks(30);
    drain();
    chk("t4_pop_count", 64'(pop_tags.size()), 64'd4);
    if (pop_tags.size() >= 3) begin
      chk("t4_order_0", 64'(pop_tags[0]), 64'd5);
      chk("t4_order_1", 64'(pop_tags[1]), 64'd9);
      chk("t4_order_2", 64'(pop_tags[2]), 64'd2);
    end

    // Randomised mix with random memory and host back-pressure
    lat = $urandom_range(1, 20);
    for (int i = 0; i < 60; i++) begin
      rdy_mode = 3; rsp_mode = 3;
      send(1'($urandom_range(0, 1)), 46'('h100 + $urandom_range(0, 3)),
           8'($urandom_range(1, 255)), {$urandom, $urandom}, 8'($urandom));
    end
    rdy_mode = 3;
    drain();
    chk("t5_err_timeout_clear", 64'(bus.err_timeout), 64'd0);
    chk("t5_outstanding_zero", 64'(bus.outstanding), 64'd0);

    // Read data with nothing outstanding
    chk("t6_err_unexpected_pre", 64'(bus.err_unexpected), 64'd0);
    force_rdv = 1;
    tick();
    force_rdv = 0;
    tick();
    chk("t6_err_unexpected", 64'(bus.err_unexpected), 64'd1);
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    // Read timeout with a stalled memory
    do_reset();
    chk("t7_err_unexpected_cleared", 64'(bus.err_unexpected), 64'd0);
    rdy_mode = 1; lat = 100000;
    send(0, 46'h77, '0, '0, 8'h1);
    for (int i = 0; i < 10 && n_rd_issue == 0; i++) tick();
    chk("t7_read_issued", 64'(n_rd_issue), 64'd1);
    ticks(63);
    chk("t7_no_timeout_yet", 64'(bus.err_timeout), 64'd0);
    tick();
    chk("t7_timeout", 64'(bus.err_timeout), 64'd1);
    chk("t7_outstanding", 64'(bus.outstanding), 64'd1);

    // Asynchronous reset with reads in flight
    do_reset();
    rdy_mode = 2; lat = 200;
    for (int i = 0; i < 4; i++) send(0, 46'(i + 'h10), '0, '0, 8'(i));
    for (int i = 0; i < 20 && n_rd_issue < 4; i++) tick();
    chk("t8_outstanding_4", 64'(bus.outstanding), 64'd4);
    #2 rst = 1'b1;
    #1;
    chk("t8_rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("t8_rst_avm_read", 64'(bus.avm_read), 64'd0);
    chk("t8_rst_avm_write", 64'(bus.avm_write), 64'd0);
    chk("t8_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t8_rst_outstanding", 64'(bus.outstanding), 64'd0);
    chk("t8_rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
    @(negedge clk);
    cyc++;
    do_reset();
    #1;
    chk("t8_post_outstanding", 64'(bus.outstanding), 64'd0);
    chk("t8_post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t8_post_req_ready", 64'(bus.req_ready), 64'd1);
    rdy_mode = 2; lat = 6;
    send(1, 46'h55, 8'hF0, {$urandom, $urandom}, 8'h0);
    send(0, 46'h55, '0, '0, 8'h2C);
    drain();
    chk("t8_roundtrip_tag", 64'(last_pop_tag), 64'h2C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
